fnd_scan_ctrl: RTL and testbench
================================

Name: fnd_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit FND on the stopwatch board.
- Takes the stopwatch time fields, splits them into BCD digits and rotates through the digits.
- Drives the active-low digit commons and one 4-bit BCD code per scan phase into the downstream BCD-to-segment decoder.
- The decoder uses two special codes: 4'hE = blank, 4'hF = decimal point only. The blinking decimal point is produced with these codes.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- SCAN_HZ, 1000, scan-phase advance rate in Hz; one phase per tick, 8 phases per frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sw_mode  input  1  0 = show sec:msec, 1 = show hour:min.
- msec  input  7  hundredths of a second, 0..99.
- sec  input  6  seconds, 0..59.
- min  input  6  minutes, 0..59.
- hour  input  5  hours, 0..23.
- fnd_com  output  4  digit commons, active-low; bit n enables digit n (digit 0 is rightmost).
- bcd  output  4  code to the decoder: 0..9 digit, 4'hE blank, 4'hF dot.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high. All state changes on the rising edge of clk.
- Prescaler:
  - Counter runs 0..CLK_FREQ/SCAN_HZ-1, then wraps to 0.
  - scan_tick is a one-cycle pulse when the counter wraps.
- scan_sel:
  - 3-bit register, increments on scan_tick.
  - Wraps 7 -> 0.
- Mode latch:
  - mode_q samples sw_mode only on the scan_tick that wraps scan_sel 7 -> 0.
  - A mode change therefore never tears a frame.
- Field select:
  - mode_q = 0: lo = msec, hi = sec.
  - mode_q = 1: lo = min, hi = hour.
- Digit split:
  - d0 = lo%10, d1 = (lo/10)%10, d2 = hi%10, d3 = (hi/10)%10.
  - Purely combinational.
  - Out-of-range inputs (e.g. msec = 120) display modulo 100 and need no special handling.
- Per-phase mapping from scan_sel:
  - 0..3: fnd_com = ~(1<<scan_sel), bcd = d[scan_sel].
  - 4..7: fnd_com = 4'b1011 (digit 2), bcd = dot_on ? 4'hF : 4'hE.
- dot_on:
  - mode_q = 0: dot_on = (msec < 50), giving a 1 Hz, 50 % blink.
  - mode_q = 1: dot_on = sec[0], toggling each second.
- Output timing:
  - fnd_com and bcd are registered: updated the cycle after scan_sel changes (latency 1 clk).
  - Inputs change between phases: a phase displays the input values sampled at its output-register load. No further synchronisation is required; inputs are already in the clk domain.
- Reset values:
  - Prescaler 0, scan_sel 0, mode_q 0.
  - fnd_com = 4'b1111 (all off), bcd = 4'hE.
- First cycle after reset deasserts: outputs reflect phase 0 (fnd_com = 4'b1110).
- Reset mid-frame: same as power-up; any partial phase is discarded.

Optional Feature:
- Macro: FND_LEADING_ZERO_BLANK_EN.
- Defined: when a phase would show d3 == 0, bcd = 4'hE instead of 0, with fnd_com unchanged.
  - Example: sec = 7 shows " 7.xx".
- Not defined: d3 is always shown, including 0.

Decomposition:
- Shared package fnd_pkg:
  - BCD_BLANK = 4'hE, BCD_DOT = 4'hF.
  - COM_ALL_OFF = 4'b1111.
  - Phase count localparam (8).
- One natural sub-module, fnd_digit_splitter:
  - Pure combinational.
  - 7-bit value in, tens and ones BCD out.
  - Instantiated twice, once for lo and once for hi.

Test Plan:
- Sim parameters: CLK_FREQ = 1000, SCAN_HZ = 100, so one tick every 10 clks.
- Reset: hold reset 3 clks -> fnd_com = 4'b1111, bcd = 4'hE. First clk after release -> fnd_com = 4'b1110.
- Scan order: sw_mode = 0, sec = 42, msec = 37, run 80 clks -> phases show:
  - (1110, 7), (1101, 3), (1011, 2), (0111, 4).
  - Then 4 phases of (1011, F).
  - Each phase lasts 10 clks, then wraps to phase 0.
- Dot blink: msec = 50 -> phases 4..7 give bcd = 4'hE. msec = 49 -> 4'hF.
- Mode switch mid-frame: hour = 13, min = 5. Toggle sw_mode to 1 during phase 2 -> phases 2..7 still show the sec:msec frame. Next frame shows (5, 0, 3, 1) on digits 0..3.
- Leading zero (macro defined): sw_mode = 0, sec = 7 -> phase 3 gives bcd = 4'hE, fnd_com = 4'b0111. Macro undefined -> bcd = 0.
- Mid-frame reset: assert reset in phase 5 for 1 clk -> outputs go to reset values. Scan restarts at phase 0 with the full 10-clk phase length.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan controller: decoder special codes,
// digit-common patterns and the scan phase count.
package fnd_pkg;

    // Special decoder codes
    localparam logic [3:0] BCD_BLANK     = 4'hE;
    localparam logic [3:0] BCD_DOT       = 4'hF;

    // Active-low digit commons
    localparam logic [3:0] COM_ALL_OFF   = 4'b1111;
    localparam logic [3:0] COM_DOT_DIGIT = 4'b1011;

    // Four digit phases followed by four decimal-point phases per frame
    localparam int NUM_PHASES = 8;
    localparam int PHASE_W    = $clog2(NUM_PHASES);

    typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/fnd_digit_splitter.sv
// Splits a 0..127 value into its tens and ones BCD digits (modulo 100).
// Purely combinational.
module fnd_digit_splitter (
    input  logic [6:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // Constant divisors keep this a small fixed-function block
    always_comb begin
        ones = 4'(value % 7'd10);
        tens = 4'((value / 7'd10) % 7'd10);
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for the 4-digit stopwatch FND.
// Rotates through four digit phases and four decimal-point phases per frame,
// driving active-low commons and a BCD code into the segment decoder.
// Optional build macro: FND_LEADING_ZERO_BLANK_EN blanks a leading zero on
// digit 3 instead of showing 0.
module fnd_scan_ctrl #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_mode,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [3:0] bcd
);

    import fnd_pkg::*;

    localparam int               DIV     = CLK_FREQ / SCAN_HZ;
    localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             scan_tick;
    phase_t           scan_sel;
    logic             mode_q;

    logic [6:0]       lo;
    logic [6:0]       hi;
    logic [3:0]       d0, d1, d2, d3;
    logic             dot_on;

    logic [3:0]       nxt_com;
    logic [3:0]       nxt_bcd;

    assign scan_tick = (cnt_q == CNT_MAX);

    // Prescaler: one scan_tick per phase period
    always_ff @(posedge clk) begin
        if (reset)          cnt_q <= '0;
        else if (scan_tick) cnt_q <= '0;
        else                cnt_q <= cnt_q + 1'b1;
    end

    // Phase counter; the mode is only taken at a frame boundary so a frame
    // never mixes sec:msec and hour:min content
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_sel <= '0;
            mode_q   <= 1'b0;
        end else if (scan_tick) begin
            scan_sel <= scan_sel + 1'b1;
            if (scan_sel == phase_t'(NUM_PHASES - 1))
                mode_q <= sw_mode;
        end
    end

    // Field select for the low and high digit pairs
    always_comb begin
        lo = mode_q ? {1'b0, min}  : msec;
        hi = mode_q ? {2'b0, hour} : {1'b0, sec};
    end

    fnd_digit_splitter u_split_lo (
        .value (lo),
        .tens  (d1),
        .ones  (d0)
    );

    fnd_digit_splitter u_split_hi (
        .value (hi),
        .tens  (d3),
        .ones  (d2)
    );

    // Dot blinks at 1 Hz from the hundredths in sec:msec mode,
    // and follows the seconds LSB in hour:min mode
    always_comb begin
        dot_on = mode_q ? sec[0] : (msec < 7'd50);
    end

    // Per-phase common/code selection
    always_comb begin
        nxt_com = COM_DOT_DIGIT;
        nxt_bcd = dot_on ? BCD_DOT : BCD_BLANK;
        case (scan_sel)
            phase_t'(0): begin nxt_com = 4'b1110; nxt_bcd = d0; end
            phase_t'(1): begin nxt_com = 4'b1101; nxt_bcd = d1; end
            phase_t'(2): begin nxt_com = 4'b1011; nxt_bcd = d2; end
            phase_t'(3): begin
                nxt_com = 4'b0111;
`ifdef FND_LEADING_ZERO_BLANK_EN
                nxt_bcd = (d3 == 4'd0) ? BCD_BLANK : d3;
`else
                nxt_bcd = d3;
`endif
            end
            default: ;
        endcase
    end

    // Output register: one clock behind scan_sel
    always_ff @(posedge clk) begin
        if (reset) begin
            fnd_com <= COM_ALL_OFF;
            bcd     <= BCD_BLANK;
        end else begin
            fnd_com <= nxt_com;
            bcd     <= nxt_bcd;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with a 10-clock scan phase.
module tb_fnd_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       sw_mode;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [3:0] fnd_com;
    logic [3:0] bcd;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_com [8];
    logic [3:0] exp_bcd [8];
    logic [3:0] lz_exp;

    fnd_scan_ctrl #(
        .CLK_FREQ (1000),
        .SCAN_HZ  (100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_mode (sw_mode),
        .msec    (msec),
        .sec     (sec),
        .min     (min),
        .hour    (hour),
        .fnd_com (fnd_com),
        .bcd     (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; returns on the following falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] ecom, input logic [3:0] ebcd);
        checks++;
        assert (fnd_com === ecom) else begin
            errors++;
            $error("FAIL %s com: got %b expected %b", tag, fnd_com, ecom);
        end
        checks++;
        assert (bcd === ebcd) else begin
            errors++;
            $error("FAIL %s bcd: got %h expected %h", tag, bcd, ebcd);
        end
    endtask

    initial begin
        reset   = 1'b1;
        sw_mode = 1'b0;
        msec    = 7'd37;
        sec     = 6'd42;
        min     = 6'd5;
        hour    = 5'd13;

        // sec:msec = 42:37 frame
        exp_com[0] = 4'b1110; exp_bcd[0] = 4'd7;
        exp_com[1] = 4'b1101; exp_bcd[1] = 4'd3;
        exp_com[2] = 4'b1011; exp_bcd[2] = 4'd2;
        exp_com[3] = 4'b0111; exp_bcd[3] = 4'd4;
        for (int p = 4; p < 8; p++) begin
            exp_com[p] = 4'b1011; exp_bcd[p] = 4'hF;
        end

        // Reset held for 3 clocks
        step(3);
        chk("reset", 4'b1111, 4'hE);
        reset = 1'b0;

        // Edges 1..80 after release: phase p shown on edges 10p+1..10p+10
        for (int k = 1; k <= 80; k++) begin
            step(1);
            chk($sformatf("scan_k%0d", k), exp_com[(k-1)/10], exp_bcd[(k-1)/10]);
        end
        step(1);                                  // edge 81
        chk("wrap_ph0", 4'b1110, 4'd7);

        // Dot blink threshold
        msec = 7'd50;
        step(44);                                 // edge 125, phase 4
        chk("dot_msec50", 4'b1011, 4'hE);
        msec = 7'd49;
        step(10);                                 // edge 135, phase 5
        chk("dot_msec49", 4'b1011, 4'hF);
        msec = 7'd37;

        // Mode switch during phase 2 of the frame starting at edge 161
        step(47);                                 // edge 182
        sw_mode = 1'b1;
        step(3);                                  // edge 185
        chk("mode_ph2_old", 4'b1011, 4'd2);
        step(10);                                 // edge 195
        chk("mode_ph3_old", 4'b0111, 4'd4);
        step(10);                                 // edge 205
        chk("mode_ph4_old", 4'b1011, 4'hF);
        step(30);                                 // edge 235
        chk("mode_ph7_old", 4'b1011, 4'hF);
        step(10);                                 // edge 245
        chk("mode_ph0_new", 4'b1110, 4'd5);
        step(10);
        chk("mode_ph1_new", 4'b1101, 4'd0);
        step(10);
        chk("mode_ph2_new", 4'b1011, 4'd3);
        step(10);
        chk("mode_ph3_new", 4'b0111, 4'd1);
        step(10);                                 // edge 285, sec even
        chk("mode_dot_even", 4'b1011, 4'hE);
        sec = 6'd43;
        step(10);                                 // edge 295, phase 5
        chk("mode_dot_odd", 4'b1011, 4'hF);

        // Mid-frame reset in phase 5
        reset = 1'b1;
        step(1);
        chk("midreset", 4'b1111, 4'hE);
        reset   = 1'b0;
        sw_mode = 1'b0;
        sec     = 6'd42;
        step(1);                                  // edge 1 after release
        chk("restart_k1", 4'b1110, 4'd7);
        step(9);                                  // edge 10
        chk("restart_k10", 4'b1110, 4'd7);
        step(1);                                  // edge 11
        chk("restart_k11", 4'b1101, 4'd3);

        // Leading zero on digit 3
        sec = 6'd7;
        step(14);                                 // edge 25, phase 2
        chk("lz_ph2", 4'b1011, 4'd7);
`ifdef FND_LEADING_ZERO_BLANK_EN
        lz_exp = 4'hE;
`else
        lz_exp = 4'd0;
`endif
        step(10);                                 // edge 35, phase 3
        chk("lz_ph3", 4'b0111, lz_exp);

        // Out-of-range msec displays modulo 100
        msec = 7'd120;
        step(10);                                 // edge 45, phase 4
        chk("oor_dot", 4'b1011, 4'hE);
        step(40);                                 // edge 85, phase 0
        chk("oor_d0", 4'b1110, 4'd0);
        step(10);                                 // edge 95, phase 1
        chk("oor_d1", 4'b1101, 4'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
